// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder over a word-addressed register file.
// Independent write and read FSMs share one storage array; state is exposed on debug ports.
module axi4_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARSETN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [1:0]            dbg_wr_state,
    output logic                  dbg_rd_state
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_WORDS * 4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [3:0]            w_strb_q;

    logic                  aw_hs, w_hs, ar_hs, wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_in_range, rd_in_range;

    // A transfer happens only on a cycle where VALID and READY are both high;
    // VALID held across other cycles has no effect, and READY never depends on VALID.
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // Whichever half arrives on the committing edge comes from the bus, the other from its latch.
    assign wr_addr = aw_hs ? AWADDR : aw_addr_q;
    assign wr_data = w_hs ? WDATA : w_data_q;
    assign wr_strb = w_hs ? WSTRB : w_strb_q;

    assign wr_idx      = wr_addr[IDX_W+1:2];
    assign wr_in_range = wr_addr < LIMIT;
    assign rd_idx      = ARADDR[IDX_W+1:2];
    assign rd_in_range = ARADDR < LIMIT;

    assign wr_commit = (wr_state == W_IDLE && aw_hs && w_hs) ||
                       (wr_state == W_WAIT_W && w_hs) ||
                       (wr_state == W_WAIT_AW && aw_hs);

    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;

    always_ff @(posedge ACLK) begin
        if (!ARSETN) begin
            wr_state  <= W_IDLE;
            AWREADY   <= 1'b1;
            WREADY    <= 1'b1;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (aw_hs) begin
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (wr_commit) begin
                if (wr_in_range) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
                wr_state <= W_RESP;
                AWREADY  <= 1'b0;
                WREADY   <= 1'b0;
                BVALID   <= 1'b1;
                BRESP    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                case (wr_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            wr_state <= W_WAIT_W;
                            AWREADY  <= 1'b0;
                        end else if (w_hs) begin
                            wr_state <= W_WAIT_AW;
                            WREADY   <= 1'b0;
                        end
                    end
                    W_RESP: begin
                        if (BREADY) begin
                            wr_state <= W_IDLE;
                            AWREADY  <= 1'b1;
                            WREADY   <= 1'b1;
                            BVALID   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reads sample storage before any same-edge write lands, so they see the old value.
    always_ff @(posedge ACLK) begin
        if (!ARSETN) begin
            rd_state <= R_IDLE;
            ARREADY  <= 1'b1;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= R_DATA;
                        ARREADY  <= 1'b0;
                        RVALID   <= 1'b1;
                        RDATA    <= rd_in_range ? mem[rd_idx] : '0;
                        RRESP    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        rd_state <= R_IDLE;
                        ARREADY  <= 1'b1;
                        RVALID   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed and random checks of axi4_lite_slave_regs against a small register-file model,
// with expected responses queued at drive time and popped when the DUT responds.
module tb_axi4_lite_slave_regs;

    localparam int NW = 16;

    logic        ACLK = 1'b0;
    logic        ARSETN;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;
    logic [1:0]  dbg_wr_state;
    logic        dbg_rd_state;

    axi4_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(NW)) dut (
        .ACLK(ACLK), .ARSETN(ARSETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  exp_rresp_q[$];
    logic [1:0]  exp_bresp_q[$];
    logic [31:0] mdl [NW];

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] addr);
        return addr < 32'(NW * 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        exp_bresp_q.push_back(in_rng(addr) ? 2'b00 : 2'b10);
        if (in_rng(addr)) mdl[addr[5:2]] = merge(mdl[addr[5:2]], data, strb);
    endtask

    task automatic model_read(input logic [31:0] addr);
        exp_q.push_back(in_rng(addr) ? mdl[addr[5:2]] : 32'h0);
        exp_rresp_q.push_back(in_rng(addr) ? 2'b00 : 2'b10);
    endtask

    task automatic collect_b(input int stall);
        int n = 0;
        while (!BVALID && n < 8) begin
            step();
            n++;
        end
        check("b_latency", 32'(n), 32'd0);
        for (int s = 0; s < stall; s++) begin
            check("b_hold_valid", {31'd0, BVALID}, 32'd1);
            check("b_hold_resp", {30'd0, BRESP}, {30'd0, exp_bresp_q[0]});
            check("b_hold_awready", {31'd0, AWREADY}, 32'd0);
            check("b_hold_wready", {31'd0, WREADY}, 32'd0);
            step();
        end
        check("bresp", {30'd0, BRESP}, {30'd0, exp_bresp_q.pop_front()});
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check("bvalid_clear", {31'd0, BVALID}, 32'd0);
    endtask

    task automatic collect_r(input int stall);
        int n = 0;
        while (!RVALID && n < 8) begin
            step();
            n++;
        end
        check("r_latency", 32'(n), 32'd0);
        for (int s = 0; s < stall; s++) begin
            check("r_hold_valid", {31'd0, RVALID}, 32'd1);
            check("r_hold_data", RDATA, exp_q[0]);
            check("r_hold_resp", {30'd0, RRESP}, {30'd0, exp_rresp_q[0]});
            check("r_hold_arready", {31'd0, ARREADY}, 32'd0);
            step();
        end
        check("rdata", RDATA, exp_q.pop_front());
        check("rresp", {30'd0, RRESP}, {30'd0, exp_rresp_q.pop_front()});
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check("rvalid_clear", {31'd0, RVALID}, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int stall);
        model_write(addr, data, strb);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        collect_b(stall);
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall);
        model_read(addr);
        ARADDR = addr;
        ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        collect_r(stall);
    endtask

    initial begin
        logic [31:0] a, d;
        ARSETN = 1'b0;
        AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < NW; i++) mdl[i] = 32'h0;
        repeat (3) step();

        check("rst_awready", {31'd0, AWREADY}, 32'd1);
        check("rst_wready", {31'd0, WREADY}, 32'd1);
        check("rst_arready", {31'd0, ARREADY}, 32'd1);
        check("rst_bvalid", {31'd0, BVALID}, 32'd0);
        check("rst_rvalid", {31'd0, RVALID}, 32'd0);
        check("rst_bresp", {30'd0, BRESP}, 32'd0);
        check("rst_rresp", {30'd0, RRESP}, 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        ARSETN = 1'b1;
        step();

        // AW and W together, then read back
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0);
        do_read(32'h04, 0);

        // W leads AW by three cycles
        model_write(32'h0C, 32'hCAFEF00D, 4'hF);
        WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("waw_awready", {31'd0, AWREADY}, 32'd1);
            check("waw_wready", {31'd0, WREADY}, 32'd0);
            check("waw_bvalid", {31'd0, BVALID}, 32'd0);
            step();
        end
        AWADDR = 32'h0C; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        collect_b(0);
        do_read(32'h0C, 0);

        // AW leads W, partial strobe into a cleared word
        model_write(32'h10, 32'h01020304, 4'b1100);
        AWADDR = 32'h10; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("ww_awready", {31'd0, AWREADY}, 32'd0);
            check("ww_wready", {31'd0, WREADY}, 32'd1);
            step();
        end
        WDATA = 32'h01020304; WSTRB = 4'b1100; WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        collect_b(0);
        do_read(32'h10, 0);

        // byte-lane merge: expect 0x11BB33DD
        do_write(32'h08, 32'h11223344, 4'hF, 0);
        do_write(32'h08, 32'hAABBCCDD, 4'b0101, 0);
        do_read(32'h08, 0);
        check("merge_literal", mdl[2], 32'h11BB33DD);

        // out-of-range accesses
        do_write(32'h40, 32'h12345678, 4'hF, 0);
        do_write(32'hFFFFFFFC, 32'h87654321, 4'hF, 0);
        do_read(32'h40, 0);
        do_read(32'h7F, 0);

        // back-pressure on both responses
        do_write(32'h18, 32'h5555AAAA, 4'hF, 5);
        do_read(32'h18, 5);
        do_write(32'h44, 32'h0, 4'hF, 5);
        do_read(32'h48, 5);

        // read and write to the same word committing on the same edge
        model_read(32'h18);
        model_write(32'h18, 32'h0BADF00D, 4'hF);
        AWADDR = 32'h18; WDATA = 32'h0BADF00D; WSTRB = 4'hF; ARADDR = 32'h18;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        collect_b(0);
        collect_r(0);
        do_read(32'h18, 0);

        // random mix, including out-of-range and unaligned addresses
        for (int i = 0; i < 24; i++) begin
            a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            end else begin
                do_read(a, $urandom_range(0, 2));
            end
        end

        // full sweep against the model
        for (int i = 0; i < NW; i++) do_read(32'(i * 4), 0);

        // reset while waiting for W
        do_write(32'h00, 32'h0000005A, 4'hF, 0);
        AWADDR = 32'h00; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        check("pre_rst_awready", {31'd0, AWREADY}, 32'd0);
        check("pre_rst_wready", {31'd0, WREADY}, 32'd1);
        ARSETN = 1'b0;
        step();
        check("mid_rst_awready", {31'd0, AWREADY}, 32'd1);
        check("mid_rst_wready", {31'd0, WREADY}, 32'd1);
        check("mid_rst_bvalid", {31'd0, BVALID}, 32'd0);
        ARSETN = 1'b1;
        for (int i = 0; i < NW; i++) mdl[i] = 32'h0;
        step();
        do_read(32'h00, 0);
        do_read(32'h04, 0);

        check("exp_q_empty", 32'(exp_q.size() + exp_bresp_q.size() + exp_rresp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
